gat_feat_streamer: RTL and testbench

Output-side stage of the GAT accelerator, placed directly downstream of the `gat_top_wrapper` result port. When `gat_ready` rises, the block walks the new-feature BRAM read port (`feat_bram_addrb` / `feat_bram_dout`) from address 0. It absorbs the BRAM read latency in a small credit-controlled FIFO and presents the words on an AXI-Stream master with `tlast` on the final word. Status outputs go to the register bank.

---
 rtl/gat_feat_streamer.sv | 208 ++++++++++++++++++++
 tb/tb_gat_feat_streamer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gat_feat_streamer.sv
// gat_feat_streamer: output stage of the GAT accelerator.
// Reads the new-feature BRAM from word 0 up to word N-1. The BRAM read latency
// is absorbed by a small FIFO, and issue is throttled by a credit count
// (FIFO slots not yet claimed). Words leave on an AXI-Stream master, and tlast
// marks word N-1.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a gat_ready rising edge; N==0 completes at once
// STREAM  | issuing one BRAM read per cycle while credit is available
// DRAIN   | all reads issued; emptying latency pipe and FIFO to the stream
module gat_feat_streamer #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NEW_FEATURE_DEPTH  = 43328,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY         = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gat_ready,
  input  logic [NEW_FEATURE_ADDR_W:0]   cfg_num_words,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          strm_busy,
  output logic                          strm_done,
  output logic [NEW_FEATURE_ADDR_W:0]   strm_word_cnt
);

  localparam int CW    = NEW_FEATURE_ADDR_W + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Occupancy width covers FIFO contents plus reads still in the latency pipe.
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                gat_ready_q;
  logic [CW-1:0]       n_q, n_d;
  logic [CW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]       word_cnt_q, word_cnt_d;
  logic [CW-1:0]       addr_hold_q, addr_hold_d;
  logic                done_q, done_d;

  logic [RD_LATENCY-1:0] vld_pipe_q;
  logic [RD_LATENCY-1:0] last_pipe_q;

  // FIFO entry: {last flag, data}
  logic [NEW_FEATURE_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]           fifo_cnt_q;

  logic                       gat_rise;
  logic [OCC_W-1:0]           inflight;
  logic                       credit_ok;
  logic                       issue;
  logic                       push;
  logic                       pop;
  logic                       fifo_full;
  logic [NEW_FEATURE_WIDTH:0] head_w;

  assign gat_rise  = gat_ready & ~gat_ready_q;
  assign credit_ok = (fifo_cnt_q + inflight) < OCC_W'(FIFO_DEPTH);
  assign issue     = (state_q == S_STREAM) && credit_ok && (issue_cnt_q < n_q);
  assign push      = vld_pipe_q[RD_LATENCY-1];
  assign fifo_full = (fifo_cnt_q == OCC_W'(FIFO_DEPTH));
  assign head_w    = mem_q[rd_ptr_q];

  // Output stream comes straight from registered FIFO state, so tvalid never
  // depends on tready.
  assign m_axis_tvalid   = (fifo_cnt_q != '0);
  assign m_axis_tdata    = m_axis_tvalid ? head_w[NEW_FEATURE_WIDTH-1:0] : '0;
  assign m_axis_tlast    = m_axis_tvalid & head_w[NEW_FEATURE_WIDTH];
  assign pop             = m_axis_tvalid & m_axis_tready;

  // Present the word being issued this cycle. Otherwise hold the last
  // issued address.
  assign feat_bram_addrb = issue ? {issue_cnt_q, 2'b00} : {addr_hold_q, 2'b00};

  assign strm_busy     = (state_q != S_IDLE);
  assign strm_done     = done_q;
  assign strm_word_cnt = word_cnt_q;

  // Count of reads issued whose data has not yet reached the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + OCC_W'(vld_pipe_q[i]);
    end
  end

  // Next-state logic for the FSM, the counters and the sticky done flag.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    issue_cnt_d = issue_cnt_q;
    word_cnt_d  = word_cnt_q + CW'(pop);
    done_d      = done_q;
    addr_hold_d = issue ? issue_cnt_q : addr_hold_q;

    unique case (state_q)
      S_IDLE: begin
        if (gat_rise) begin
          n_d         = cfg_num_words;
          done_d      = 1'b0;
          word_cnt_d  = '0;
          issue_cnt_d = '0;
          addr_hold_d = '0;
          if (cfg_num_words == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + CW'(1);
          if ((issue_cnt_q + CW'(1)) == n_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Finish on the cycle the last buffered word is handed off.
        if ((inflight == '0) && !push && (fifo_cnt_q == OCC_W'(pop))) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gat_ready_q <= 1'b0;
      n_q         <= '0;
      issue_cnt_q <= '0;
      word_cnt_q  <= '0;
      addr_hold_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gat_ready_q <= gat_ready;
      n_q         <= n_d;
      issue_cnt_q <= issue_cnt_d;
      word_cnt_q  <= word_cnt_d;
      addr_hold_q <= addr_hold_d;
      done_q      <= done_d;
    end
  end

  // Latency pipe: a valid bit and a last flag ride along with each read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      vld_pipe_q[0]  <= issue;
      last_pipe_q[0] <= issue && (issue_cnt_q == (n_q - CW'(1)));
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
    end
  end

  // FIFO pointers and occupancy. Push and pop in the same cycle are both taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // FIFO storage. There is no reset here because data is only read when the
  // count says the entry is occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {last_pipe_q[RD_LATENCY-1], feat_bram_dout};
    end
  end

  // The credit scheme must never let a push land on a full FIFO without a pop.
  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_gat_feat_streamer.sv
module tb_gat_feat_streamer;

  localparam int AW = 16;

  logic          clk;
  logic          rst_n;
  logic          gat_ready;
  logic [AW:0]   cfg_num_words;
  logic [AW+1:0] feat_bram_addrb;
  logic [31:0]   feat_bram_dout;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          strm_busy;
  logic          strm_done;
  logic [AW:0]   strm_word_cnt;

  int total = 0;
  int bad   = 0;

  gat_feat_streamer #(
    .NEW_FEATURE_WIDTH (32),
    .NEW_FEATURE_DEPTH (43328),
    .RD_LATENCY        (2),
    .FIFO_DEPTH        (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .gat_ready       (gat_ready),
    .cfg_num_words   (cfg_num_words),
    .feat_bram_addrb (feat_bram_addrb),
    .feat_bram_dout  (feat_bram_dout),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .strm_busy       (strm_busy),
    .strm_done       (strm_done),
    .strm_word_cnt   (strm_word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle BRAM model: address registered, then data registered.
  logic [AW+1:0] bram_a1;
  always @(posedge clk) begin
    bram_a1        <= feat_bram_addrb;
    feat_bram_dout <= 32'hA000_0000 + 32'(bram_a1 >> 2);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consume one transfer with a scoreboard. It checks order, tlast, stability
  // under stall and the final status. pulse_at>=0 injects a gat_ready re-pulse
  // together with a cfg change.
  task automatic run_xfer(input string tag, input int n, input bit rnd, input int pulse_at);
    int          idx;
    bit          stalled;
    bit          fin;
    logic [31:0] hold_d;
    logic        hold_l;
    idx     = 0;
    stalled = 1'b0;
    fin     = 1'b0;
    hold_d  = '0;
    hold_l  = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      step();
      if (stalled) begin
        chk({tag, "_stall_valid"}, 64'(m_axis_tvalid), 64'd1);
        chk({tag, "_stall_data"}, 64'(m_axis_tdata), 64'(hold_d));
        chk({tag, "_stall_last"}, 64'(m_axis_tlast), 64'(hold_l));
      end
      if (pulse_at >= 0 && cyc == pulse_at) gat_ready = 1'b0;
      if (pulse_at >= 0 && cyc == pulse_at + 1) begin
        gat_ready     = 1'b1;
        cfg_num_words = 17'd3;
      end
      if (strm_done && !strm_busy) begin
        fin = 1'b1;
      end else begin
        m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_axis_tvalid && m_axis_tready) begin
          chk({tag, "_data"}, 64'(m_axis_tdata), 64'(32'hA000_0000 + idx));
          chk({tag, "_last"}, 64'(m_axis_tlast), 64'(idx == n - 1));
          idx++;
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        hold_d  = m_axis_tdata;
        hold_l  = m_axis_tlast;
      end
    end
    chk({tag, "_finished"}, 64'(fin), 64'd1);
    chk({tag, "_beats"}, 64'(idx), 64'(n));
    chk({tag, "_word_cnt"}, 64'(strm_word_cnt), 64'(n));
    chk({tag, "_tvalid_after"}, 64'(m_axis_tvalid), 64'd0);
  endtask

  initial begin
    bit reached;
    rst_n         = 1'b0;
    gat_ready     = 1'b0;
    cfg_num_words = '0;
    m_axis_tready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_addrb", 64'(feat_bram_addrb), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_busy", 64'(strm_busy), 64'd0);
    chk("rst_done", 64'(strm_done), 64'd0);
    chk("rst_wcnt", 64'(strm_word_cnt), 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 64'(strm_busy), 64'd0);

    // T1: N=16, tready=1, cycle-exact timing
    cfg_num_words = 17'd16;
    m_axis_tready = 1'b1;
    gat_ready     = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step();
      if (k <= 16) chk("t1_addrb", 64'(feat_bram_addrb), 64'(4 * (k - 1)));
      if (k == 1) chk("t1_busy_c1", 64'(strm_busy), 64'd1);
      if (k < 4) begin
        chk("t1_no_valid_early", 64'(m_axis_tvalid), 64'd0);
      end else if (k <= 19) begin
        chk("t1_valid", 64'(m_axis_tvalid), 64'd1);
        chk("t1_data", 64'(m_axis_tdata), 64'(32'hA000_0000 + (k - 4)));
        chk("t1_last", 64'(m_axis_tlast), 64'(k == 19));
        chk("t1_done_early", 64'(strm_done), 64'd0);
      end else if (k == 20) begin
        chk("t1_done_c20", 64'(strm_done), 64'd1);
        chk("t1_busy_c20", 64'(strm_busy), 64'd0);
        chk("t1_valid_c20", 64'(m_axis_tvalid), 64'd0);
        chk("t1_wcnt", 64'(strm_word_cnt), 64'd16);
      end
    end

    // T2: N=16, random tready
    gat_ready = 1'b0;
    step();
    cfg_num_words = 17'd16;
    gat_ready     = 1'b1;
    run_xfer("t2", 16, 1'b1, -1);

    // T3: N=8, tready held low 20 cycles
    gat_ready = 1'b0;
    step();
    m_axis_tready = 1'b0;
    cfg_num_words = 17'd8;
    gat_ready     = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k <= 4) chk("t3_addrb_issue", 64'(feat_bram_addrb), 64'(4 * (k - 1)));
      else        chk("t3_addrb_hold", 64'(feat_bram_addrb), 64'd12);
      if (k >= 4) begin
        chk("t3_stall_valid", 64'(m_axis_tvalid), 64'd1);
        chk("t3_stall_data", 64'(m_axis_tdata), 64'(32'hA000_0000));
      end
    end
    run_xfer("t3", 8, 1'b0, -1);

    // T4: N=0 completes immediately with no beats
    gat_ready = 1'b0;
    step();
    cfg_num_words = 17'd0;
    gat_ready     = 1'b1;
    step();
    chk("t4_done", 64'(strm_done), 64'd1);
    chk("t4_busy", 64'(strm_busy), 64'd0);
    chk("t4_wcnt", 64'(strm_word_cnt), 64'd0);
    for (int k = 0; k < 5; k++) begin
      chk("t4_no_valid", 64'(m_axis_tvalid), 64'd0);
      chk("t4_no_busy", 64'(strm_busy), 64'd0);
      step();
    end

    // T5: reset after 5 of 16 beats, then full restart
    gat_ready = 1'b0;
    step();
    cfg_num_words = 17'd16;
    m_axis_tready = 1'b1;
    gat_ready     = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 40 && !reached; k++) begin
      step();
      if (strm_word_cnt == 17'd5) reached = 1'b1;
    end
    chk("t5_reach5", 64'(reached), 64'd1);
    #2;
    rst_n     = 1'b0;
    gat_ready = 1'b0;
    #1;
    chk("t5_async_addrb", 64'(feat_bram_addrb), 64'd0);
    chk("t5_async_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t5_async_tlast", 64'(m_axis_tlast), 64'd0);
    chk("t5_async_tdata", 64'(m_axis_tdata), 64'd0);
    chk("t5_async_busy", 64'(strm_busy), 64'd0);
    chk("t5_async_done", 64'(strm_done), 64'd0);
    chk("t5_async_wcnt", 64'(strm_word_cnt), 64'd0);
    step();
    step();
    chk("t5_rst_no_valid", 64'(m_axis_tvalid), 64'd0);
    rst_n = 1'b1;
    step();
    gat_ready = 1'b1;
    step();
    chk("t5_restart_addr0", 64'(feat_bram_addrb), 64'd0);
    chk("t5_restart_busy", 64'(strm_busy), 64'd1);
    step();
    chk("t5_restart_addr1", 64'(feat_bram_addrb), 64'd4);
    run_xfer("t5", 16, 1'b0, -1);

    // T6: re-pulse mid-transfer is ignored; a later rise restarts
    gat_ready = 1'b0;
    step();
    cfg_num_words = 17'd16;
    gat_ready     = 1'b1;
    run_xfer("t6", 16, 1'b0, 5);
    chk("t6_done_before_restart", 64'(strm_done), 64'd1);
    gat_ready = 1'b0;
    step();
    cfg_num_words = 17'd4;
    gat_ready     = 1'b1;
    step();
    chk("t6b_done_cleared", 64'(strm_done), 64'd0);
    chk("t6b_busy", 64'(strm_busy), 64'd1);
    run_xfer("t6b", 4, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
